// File: rtl/umai_pkg.sv
// Shared types and constants for the UMAI tx packetizer: flit layout, widths and FSM states.
package umai_pkg;

  localparam int unsigned AddrW        = 32;
  localparam int unsigned LenW         = 6;
  localparam int unsigned DataW        = 512;
  localparam int unsigned FlitW        = 72;
  localparam int unsigned PayloadW     = 64;
  localparam int unsigned FlitsPerBeat = 8;
  localparam int unsigned IdxW         = 3;

  // Header bit positions inside a flit
  localparam int unsigned TypeHi  = 71;
  localparam int unsigned TypeLo  = 70;
  localparam int unsigned IdxHi   = 69;
  localparam int unsigned IdxLo   = 67;
  localparam int unsigned LastBit = 66;

  typedef enum logic [1:0] {
    FLIT_WCMD  = 2'b01,
    FLIT_RCMD  = 2'b10,
    FLIT_WDATA = 2'b11
  } flit_type_e;

  typedef enum logic [0:0] {
    StIdle,
    StData
  } state_e;

  function automatic logic [FlitW-1:0] mk_flit(input flit_type_e       ftype,
                                               input logic [IdxW-1:0]  idx,
                                               input logic             last,
                                               input logic [PayloadW-1:0] payload);
    return {ftype, idx, last, 2'b00, payload};
  endfunction

  function automatic logic [PayloadW-1:0] cmd_payload(input logic [LenW-1:0]  len,
                                                      input logic [AddrW-1:0] addr);
    return {{(PayloadW - LenW - AddrW){1'b0}}, len, addr};
  endfunction

endpackage

// File: rtl/umai_flit_obuf.sv
// One-entry registered valid/ready stage; o_valid and o_data come straight from flops.
module umai_flit_obuf
  import umai_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [FlitW-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [FlitW-1:0] o_data
);

  logic             valid_q, valid_d;
  logic [FlitW-1:0] data_q, data_d;

  // Accept when empty or when the held flit leaves this cycle.
  assign o_ready = !valid_q || i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (o_ready) begin
      valid_d = i_valid;
      if (i_valid) begin
        data_d = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/umai_tx_packetizer.sv
// Turns UMAI write/read commands and 512-bit write beats into 72-bit AIB tx flits.
module umai_tx_packetizer
  import umai_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_umai_slv_wcmd_valid,
  output logic             o_umai_slv_wcmd_ready,
  input  logic [AddrW-1:0] i_umai_slv_wcmd_addr,
  input  logic [LenW-1:0]  i_umai_slv_wcmd_len,
  input  logic             i_umai_slv_rcmd_valid,
  output logic             o_umai_slv_rcmd_ready,
  input  logic [AddrW-1:0] i_umai_slv_rcmd_addr,
  input  logic [LenW-1:0]  i_umai_slv_rcmd_len,
  input  logic             i_umai_slv_wvalid,
  output logic             o_umai_slv_wready,
  input  logic [DataW-1:0] i_umai_slv_wdata,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [FlitW-1:0] o_tx_data
);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;  // 1: rcmd wins the next tie
  logic [LenW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IdxW-1:0]   flit_idx_q, flit_idx_d;
  logic              buf_vld_q, buf_vld_d;
  logic [DataW-1:0]  buf_q, buf_d;

  logic              ob_valid, ob_ready;
  logic [FlitW-1:0]  ob_data;
  logic              grant_w, grant_r, wready;
  logic [DataW-1:0]  src_beat;
  logic [PayloadW-1:0] src_word;
  logic              last_flit;

  // Command flits are pushed on the grant edge, so the WCMD/RCMD phases collapse into IDLE.
  // With the beat buffer empty, flit 0 bypasses straight from wdata to avoid a bubble.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    flit_idx_d = flit_idx_q;
    buf_vld_d  = buf_vld_q;
    buf_d      = buf_q;
    ob_valid   = 1'b0;
    ob_data    = '0;
    grant_w    = 1'b0;
    grant_r    = 1'b0;
    wready     = 1'b0;
    src_beat   = buf_vld_q ? buf_q : i_umai_slv_wdata;
    src_word   = src_beat[{flit_idx_q, 6'd0} +: PayloadW];
    last_flit  = (flit_idx_q == 3'd7) && (beat_cnt_q == '0);

    unique case (state_q)
      StIdle: begin
        if (!i_rst && ob_ready) begin
          if (i_umai_slv_wcmd_valid && (!i_umai_slv_rcmd_valid || !rr_q)) begin
            grant_w = 1'b1;
          end else if (i_umai_slv_rcmd_valid) begin
            grant_r = 1'b1;
          end
        end
        if (grant_w) begin
          ob_valid   = 1'b1;
          ob_data    = mk_flit(FLIT_WCMD, '0, 1'b1,
                               cmd_payload(i_umai_slv_wcmd_len, i_umai_slv_wcmd_addr));
          beat_cnt_d = i_umai_slv_wcmd_len;
          flit_idx_d = '0;
          buf_vld_d  = 1'b0;
          rr_d       = 1'b1;
          state_d    = StData;
        end else if (grant_r) begin
          ob_valid = 1'b1;
          ob_data  = mk_flit(FLIT_RCMD, '0, 1'b1,
                             cmd_payload(i_umai_slv_rcmd_len, i_umai_slv_rcmd_addr));
          rr_d     = 1'b0;
        end
      end
      StData: begin
        wready   = !i_rst && ob_ready &&
                   (!buf_vld_q || (flit_idx_q == 3'd7 && beat_cnt_q != '0));
        ob_valid = buf_vld_q || i_umai_slv_wvalid;
        ob_data  = mk_flit(FLIT_WDATA, flit_idx_q, last_flit, src_word);
        if (ob_valid && ob_ready) begin
          flit_idx_d = flit_idx_q + 3'd1;
          if (!buf_vld_q) begin
            buf_d     = i_umai_slv_wdata;
            buf_vld_d = 1'b1;
          end else if (flit_idx_q == 3'd7) begin
            if (beat_cnt_q == '0) begin
              buf_vld_d = 1'b0;
              state_d   = StIdle;
            end else begin
              beat_cnt_d = beat_cnt_q - LenW'(1);
              buf_vld_d  = i_umai_slv_wvalid;
              buf_d      = i_umai_slv_wdata;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      beat_cnt_q <= '0;
      flit_idx_q <= '0;
      buf_vld_q  <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
      flit_idx_q <= flit_idx_d;
      buf_vld_q  <= buf_vld_d;
      buf_q      <= buf_d;
    end
  end

  umai_flit_obuf u_obuf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (ob_valid),
    .o_ready (ob_ready),
    .i_data  (ob_data),
    .o_valid (o_tx_valid),
    .i_ready (i_tx_ready),
    .o_data  (o_tx_data)
  );

  assign o_umai_slv_wcmd_ready = grant_w;
  assign o_umai_slv_rcmd_ready = grant_r;
  assign o_umai_slv_wready     = wready;

endmodule
